alu_addsub_issue: RTL

- Sequencing stage wrapped around the 32-bit ripple-carry adder.
- Accepts an add/subtract request over a valid/ready handshake and registers the operands, forming the effective B operand and carry-in.
- Drives the adder through a registered operand interface, waits a fixed number of cycles for the long ripple carry chain to settle, then captures Sum/Cout.
- Presents the result with ALU flags over an output valid/ready handshake.

---
 rtl/alu_addsub_issue.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_addsub_issue.sv
// alu_addsub_issue: sequencing stage wrapped around an external ripple-carry adder.
//
// Accepts ADD/SUB/ADC/SBC requests over a valid/ready handshake and registers the
// adder operands (A, effective B and carry-in). It holds them stable for
// SETTLE_CYCLES so the long carry chain can settle, then captures Sum/Cout with
// ALU flags and presents them over an output valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous abort of an in-flight operation
//   in_valid/in_ready   request handshake
//   in_op               00 ADD, 01 SUB, 10 ADC, 11 SBC
//   in_a, in_b          operands
//   in_carry            carry-in for ADC/SBC
//   adder_a/b/cin       registered operands driven to the adder
//   adder_sum/cout      adder results
//   out_valid/out_ready result handshake
//   out_result          captured sum
//   out_carry           captured Cout (subtract: 1 = no borrow)
//   out_zero/neg/ovf    zero, negative and signed-overflow flags
module alu_addsub_issue #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int unsigned Msb = WIDTH - 1;

  // 4 bits covers the largest legal load value (SETTLE_CYCLES - 1 = 14).
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_addsub_issue: SETTLE_CYCLES must be in 1..15");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("alu_addsub_issue: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              cin_q, cin_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        // flush wins over a request arriving in the same cycle.
        if (!flush && in_valid) begin
          state_d = StSettle;
          cnt_d   = CntLoad;
          a_d     = in_a;
          // op[0] selects subtract (invert B); op[1] selects the external carry.
          b_d     = in_op[0] ? ~in_b : in_b;
          cin_d   = in_op[1] ? in_carry : in_op[0];
        end
      end
      StSettle: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StDone;
          res_d   = adder_sum;
          carry_d = adder_cout;
          zero_d  = (adder_sum == '0);
          neg_d   = adder_sum[Msb];
          // Overflow: like-signed addends produced a sum of the other sign.
          ovf_d   = (a_q[Msb] == b_q[Msb]) && (adder_sum[Msb] != a_q[Msb]);
        end
      end
      StDone: begin
        // A flushed result is simply never presented again.
        if (flush || out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign adder_a    = a_q;
  assign adder_b    = b_q;
  assign adder_cin  = cin_q;
  assign out_result = res_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_ovf    = ovf_q;

  // The adder operands may only move on an accept edge.
  a_operands_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(in_ready && in_valid && !flush) |=> ($stable(adder_a) && $stable(adder_b) &&
                                           $stable(adder_cin))
  );

endmodule
